// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// One memory request is outstanding at a time; redirects flush the queue and drop stale responses.
module fetch_queue_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000,
    parameter bit              STALL_ON_BRANCH = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       mem_req_o,
    output logic [XLEN-1:0]            mem_addr_o,
    input  logic                       mem_resp_valid_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic                       dec_is_branch_o,
    output logic                       branch_pending_o,
    output logic [$clog2(DEPTH+1)-1:0] queue_count_o
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic            mem_req_q;
    logic            branch_pending_q;

    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            q_br    [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            accept;
    logic            pop;
    logic            push;
    logic            resp_is_branch;
    logic [CW-1:0]   count_after_pop;
    logic [CW-1:0]   count_after_push;
    logic [XLEN-1:0] redirect_aligned;

    assign accept           = mem_req_q & mem_resp_valid_i;
    assign pop              = (count != '0) & dec_ready_i;
    assign push             = (state == REQ) & accept & ~redirect_i;
    assign count_after_pop  = count - CW'(pop);
    assign count_after_push = count_after_pop + CW'(1);
    assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Conditional branch, jal and jalr all end sequential fetch.
    assign resp_is_branch = (mem_data_i[6:0] == 7'b1100011) ||
                            (mem_data_i[6:0] == 7'b1101111) ||
                            (mem_data_i[6:0] == 7'b1100111);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            fetch_pc         <= RESET_PC;
            req_addr         <= RESET_PC;
            mem_req_q        <= 1'b0;
            branch_pending_q <= 1'b0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_br[i]    <= 1'b0;
            end
        end else if (redirect_i) begin
            // A request still waiting in REQ must finish at its old address before the new one.
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            fetch_pc         <= redirect_aligned;
            mem_req_q        <= 1'b1;
            branch_pending_q <= 1'b0;
            if ((state == REQ) && !accept) begin
                state <= DISCARD;
            end else begin
                state    <= REQ;
                req_addr <= redirect_aligned;
            end
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= mem_data_i;
                q_pc[wr_ptr]    <= req_addr;
                q_br[wr_ptr]    <= resp_is_branch;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= push ? count_after_push : count_after_pop;

            case (state)
                IDLE: begin
                    if (count_after_pop < DEPTH_C) begin
                        state     <= REQ;
                        mem_req_q <= 1'b1;
                        req_addr  <= fetch_pc;
                    end
                end
                REQ: begin
                    if (accept) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        if (resp_is_branch && STALL_ON_BRANCH) begin
                            state            <= HOLD;
                            mem_req_q        <= 1'b0;
                            branch_pending_q <= 1'b1;
                        end else if (count_after_push < DEPTH_C) begin
                            req_addr <= fetch_pc + PC_STEP;
                        end else begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                end
                DISCARD: begin
                    if (accept) begin
                        state    <= REQ;
                        req_addr <= fetch_pc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = req_addr;
    assign dec_valid_o      = (count != '0);
    assign dec_instr_o      = q_instr[rd_ptr];
    assign dec_pc_o         = q_pc[rd_ptr];
    assign dec_is_branch_o  = q_br[rd_ptr];
    assign branch_pending_o = branch_pending_q;
    assign queue_count_o    = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios then randomized traffic, all checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_queue_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam bit          STALL    = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_is_branch_o;
    logic        branch_pending_o;
    logic [2:0]  queue_count_o;

    fetch_queue_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .STALL_ON_BRANCH(STALL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
        .dec_is_branch_o(dec_is_branch_o), .branch_pending_o(branch_pending_o),
        .queue_count_o(queue_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          br;
    } entry_t;

    // Reference model: queued entries plus the fetch engine's outstanding-request bookkeeping.
    entry_t      mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_stale;
    bit          m_hold;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          prog_sel;
    int          lat_fixed;
    bit          lat_rand;
    int          wait_cnt;
    bit          seen_valid;
    logic [31:0] seen_pc;

    function automatic bit is_br(input logic [31:0] w);
        return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
    endfunction

    // Program images: plain addi stream, addi stream with a jal at 0x80000008, hashed mix.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] h;
        logic [6:0]  op;
        if (prog_sel == 1 && addr == 32'h8000_0008) return 32'h0000_006F;
        if (prog_sel != 2) return {addr[11:0], 20'h00093};
        h = (addr * 32'h9E37_79B1) ^ (addr >> 5);
        case (h[31:28])
            4'd0:    op = 7'h63;
            4'd1:    op = 7'h6F;
            4'd2:    op = 7'h67;
            default: op = 7'h13;
        endcase
        return {h[24:0], op};
    endfunction

    function automatic int next_lat();
        if (lat_rand) return int'($urandom_range(0, 3));
        return lat_fixed;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_addr     = RESET_PC;
        m_req      = 1'b0;
        m_stale    = 1'b0;
        m_hold     = 1'b0;
    endtask

    task automatic modelStep(input bit resp, input logic [31:0] data, input bit ready,
                             input bit redir, input logic [31:0] rpc);
        bit acc;
        bit pop;
        acc = m_req && resp;
        pop = (mq.size() != 0) && ready;
        if (redir) begin
            mq.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_hold     = 1'b0;
            if (m_req && !m_stale && !acc) begin
                m_stale = 1'b1;
            end else begin
                m_stale = 1'b0;
                m_addr  = m_fetch_pc;
            end
            m_req = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_req) begin
                if (!m_hold && mq.size() < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_fetch_pc;
                end
            end else if (acc) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_fetch_pc;
                end else begin
                    mq.push_back('{instr: data, pc: m_addr, br: is_br(data)});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    if (STALL && is_br(data)) begin
                        m_req  = 1'b0;
                        m_hold = 1'b1;
                    end else if (mq.size() < DEPTH) begin
                        m_addr = m_fetch_pc;
                    end else begin
                        m_req = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock cycle: memory answers from its wait counter, outputs are checked on the falling edge.
    task automatic applyStimulus(input bit ready, input bit redir, input logic [31:0] rpc);
        bit          resp;
        bit          req_now;
        logic [31:0] data;
        req_now = mem_req_o;
        if (req_now && wait_cnt == 0) begin
            resp = 1'b1;
            data = mem_word(mem_addr_o);
        end else begin
            resp = 1'b0;
            data = $urandom;
        end
        mem_resp_valid_i = resp;
        mem_data_i       = data;
        dec_ready_i      = ready;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        #4;
        checkOutput("mem_req", 32'(mem_req_o), 32'(m_req));
        if (m_req) checkOutput("mem_addr", mem_addr_o, m_addr);
        checkOutput("dec_valid", 32'(dec_valid_o), 32'(mq.size() != 0));
        checkOutput("queue_count", 32'(queue_count_o), 32'(mq.size()));
        checkOutput("branch_pending", 32'(branch_pending_o), 32'(m_hold));
        if (mq.size() != 0) begin
            checkOutput("dec_instr", dec_instr_o, mq[0].instr);
            checkOutput("dec_pc", dec_pc_o, mq[0].pc);
            checkOutput("dec_is_branch", 32'(dec_is_branch_o), 32'(mq[0].br));
        end
        seen_valid = dec_valid_o;
        seen_pc    = dec_pc_o;
        @(posedge clk_i);
        if (req_now && resp) wait_cnt = next_lat();
        else if (req_now && wait_cnt > 0) wait_cnt--;
        modelStep(resp, data, ready, redir, rpc);
        #1;
    endtask

    task automatic doReset();
        rst_i            = 1'b1;
        mem_resp_valid_i = 1'b0;
        redirect_i       = 1'b0;
        dec_ready_i      = 1'b0;
        @(posedge clk_i);
        modelReset();
        wait_cnt = next_lat();
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          rdy;
        bit          rd;
        bit          found;
        logic [31:0] rpc;
        int          first;
        logic [31:0] pcs[$];

        rst_i = 1'b1; mem_resp_valid_i = 1'b0; mem_data_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; dec_ready_i = 1'b0;
        prog_sel = 0; lat_fixed = 0; lat_rand = 1'b0; wait_cnt = 0;
        modelReset();
        @(posedge clk_i);
        #1;

        // Reset release, sequential fetch and first-entry latency.
        $display("[TB] sequential fetch after reset");
        doReset();
        first = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            if (seen_valid && first < 0) first = i;
            if (seen_valid) pcs.push_back(seen_pc);
        end
        checkOutput("first_valid_cycle", 32'(first), 32'd2);
        checkOutput("seq_pc0", pcs[0], 32'h8000_0000);
        checkOutput("seq_pc1", pcs[1], 32'h8000_0004);
        checkOutput("seq_pc2", pcs[2], 32'h8000_0008);

        // Fill the queue with decode stalled, then release one entry.
        $display("[TB] full queue");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("full_count", 32'(queue_count_o), 32'd4);
        checkOutput("full_req", 32'(mem_req_o), 32'd0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("pop_count", 32'(queue_count_o), 32'd3);
        checkOutput("pop_req", 32'(mem_req_o), 32'd1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("refill_count", 32'(queue_count_o), 32'd4);
        checkOutput("refill_req", 32'(mem_req_o), 32'd0);

        // jal at 0x80000008 holds fetch until the redirect.
        $display("[TB] branch hold");
        prog_sel = 1;
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("hold_pending", 32'(branch_pending_o), 32'd1);
        checkOutput("hold_req", 32'(mem_req_o), 32'd0);
        checkOutput("hold_count", 32'(queue_count_o), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'h8000_0100);
        checkOutput("redir_addr", mem_addr_o, 32'h8000_0100);
        checkOutput("redir_req", 32'(mem_req_o), 32'd1);
        checkOutput("redir_pending", 32'(branch_pending_o), 32'd0);
        checkOutput("redir_count", 32'(queue_count_o), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

        // Redirect while a slow response is still outstanding.
        $display("[TB] redirect in flight");
        prog_sel = 0; lat_fixed = 3;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_req_o && mem_addr_o == 32'h8000_0010) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("inflight_req10_seen", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0040);
        checkOutput("inflight_hold_addr", mem_addr_o, 32'h8000_0010);
        checkOutput("inflight_count", 32'(queue_count_o), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mem_addr_o == 32'h8000_0040) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("inflight_new_addr_seen", 32'(found), 32'd1);
        checkOutput("inflight_dropped", 32'(queue_count_o), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);

        // Misaligned redirect coinciding with a response and a pop.
        $display("[TB] simultaneous redirect, response and pop");
        lat_fixed = 0;
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("sim_pre_count", 32'(queue_count_o), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h8000_0042);
        checkOutput("sim_count", 32'(queue_count_o), 32'd0);
        checkOutput("sim_addr", mem_addr_o, 32'h8000_0040);
        checkOutput("sim_req", 32'(mem_req_o), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

        // Reset with entries queued and a request pending.
        $display("[TB] mid-operation reset");
        lat_fixed = 2;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (queue_count_o == 3'd3 && mem_req_o) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, '0);
        end
        checkOutput("midrst_setup", 32'(found), 32'd1);
        doReset();
        checkOutput("midrst_req", 32'(mem_req_o), 32'd0);
        checkOutput("midrst_addr", mem_addr_o, 32'h8000_0000);
        checkOutput("midrst_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("midrst_instr", dec_instr_o, 32'd0);
        checkOutput("midrst_pc", dec_pc_o, 32'd0);
        checkOutput("midrst_br", 32'(dec_is_branch_o), 32'd0);
        checkOutput("midrst_pending", 32'(branch_pending_o), 32'd0);
        checkOutput("midrst_count", 32'(queue_count_o), 32'd0);

        // Randomized traffic: mixed program, variable latency, random redirects and resets.
        $display("[TB] randomized traffic");
        prog_sel = 2; lat_rand = 1'b1;
        doReset();
        for (int c = 0; c < 2000; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rd  = branch_pending_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                1, 2:    rpc = $urandom;
                default: rpc = RESET_PC + $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 299) == 0) doReset();
            else applyStimulus(rdy, rd, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction fetch stage; replaces single-instruction fetch with a DEPTH-entry prefetch queue between instruction memory and decode.
- Issues one memory request at a time, queues {instruction, pc, is_branch} entries, and presents the queue head to decode with a valid/ready handshake.
- Handles execute-stage redirects by flushing the queue and discarding any in-flight response.
- STALL_ON_BRANCH optionally holds fetch after a branch until the redirect arrives.

Parameters:
- XLEN, 32, instruction/address width.
- DEPTH, 4, queue entries; power of 2, >= 2.
- RESET_PC, 32'h8000_0000, fetch PC after reset.
- STALL_ON_BRANCH, 1, 1 = stop fetching after queuing a branch until redirect_i; 0 = keep fetching sequentially.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- mem_req_o  out  1  request; held high until accepted.
- mem_addr_o  out  XLEN  request address; stable while mem_req_o=1.
- mem_resp_valid_i  in  1  response strobe; meaningful only while mem_req_o=1.
- mem_data_i  in  XLEN  instruction word; valid with mem_resp_valid_i.
- redirect_i  in  1  one-cycle pulse from execute: new PC available.
- redirect_pc_i  in  XLEN  redirect target.
- dec_valid_o  out  1  queue head valid.
- dec_ready_i  in  1  decode accepts head.
- dec_instr_o  out  XLEN  head instruction.
- dec_pc_o  out  XLEN  head PC.
- dec_is_branch_o  out  1  head opcode[6:0] is 1100011, 1101111 or 1100111.
- branch_pending_o  out  1  high in HOLD state.
- queue_count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, queue empty.
  - Outputs: mem_req_o=0, mem_addr_o=RESET_PC, dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, dec_is_branch_o=0, branch_pending_o=0, queue_count_o=0.
  - Reset mid-operation aborts everything. Memory shares rst_i, so no stale response follows reset.
- Response acceptance: a response is accepted when mem_req_o && mem_resp_valid_i.
- Pop: occurs when dec_valid_o && dec_ready_i. dec_valid_o = (count != 0). Head outputs come straight from the queue registers.
- States and transitions:
  - IDLE: mem_req_o=0. Go to REQ when count_after_pop < DEPTH, where count_after_pop = count minus this cycle's pop.
  - REQ: mem_req_o=1, mem_addr_o=req_addr (latched = fetch_pc on entry).
    - On acceptance: push {mem_data_i, req_addr, is_branch}; fetch_pc += 4 (mod 2^XLEN, wrap allowed).
    - Next state: HOLD if is_branch && STALL_ON_BRANCH; else REQ if post-push count < DEPTH; else IDLE.
  - HOLD: mem_req_o=0. Wait for redirect_i.
  - DISCARD: mem_req_o=1 at the old req_addr. On response, drop the data (no push) and go to REQ with req_addr=fetch_pc.
- Redirect (redirect_i=1):
  - Highest priority.
  - Queue flushed to count=0. A same-cycle pop and a same-cycle push are both cancelled.
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - Next state: DISCARD if state=REQ and no response this cycle; otherwise REQ (response, if any, dropped).
- Request rules:
  - A request is issued only with a free slot, so a push into a full queue never occurs.
  - A push and a pop in the same cycle leave the count unchanged.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. Count distinguishes full from empty.
- Latency (zero-wait memory, response in the first REQ cycle):
  - Reset release at edge 0 → REQ at edge 1 → entry visible (dec_valid_o=1) after edge 2.
  - Steady state: one instruction per cycle while decode is ready and the queue is not full.

Test Plan:
- Reset/sequential: release reset, zero-wait memory returning addi words, dec_ready_i=1 → dec_pc_o sequence 0x80000000, 0x80000004, 0x80000008…; first dec_valid_o 2 cycles after reset release.
- Full queue: DEPTH=4, dec_ready_i=0 → queue_count_o reaches 4, mem_req_o drops to 0. Raise dec_ready_i for 1 cycle → count 3, new request next cycle, count back to 4.
- Branch hold: STALL_ON_BRANCH=1, word at 0x80000008 is 0x0000006F (jal) → branch_pending_o=1, no further requests. Pulse redirect_i with 0x80000100 → queue flushed, next mem_addr_o=0x80000100, branch_pending_o=0.
- Redirect in flight: 3-cycle memory latency; redirect_i to 0x80000040 one cycle after request to 0x80000010 → address held at 0x80000010 until response; that response not queued; next request 0x80000040.
- Misaligned redirect and simultaneous events: redirect_pc_i=0x80000042 in the same cycle as a response and a pop → count=0, no push, next mem_addr_o=0x80000040.
- Mid-operation reset: assert rst_i with 3 entries queued and a request pending → next cycle all outputs at reset values, mem_addr_o=0x80000000.
